// File: rtl/sonic_phy_mgmt_pkg.sv
// rtl/sonic_phy_mgmt_pkg.sv - shared types and defaults for the PHY management master
// Purpose: command opcode encoding, FSM state encoding and default bus widths.
// Ports: none (package).
package sonic_phy_mgmt_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_RMW   = 2'b10,
      OP_POLL  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      MERGE = 3'd2,
      WR    = 3'd3,
      CHECK = 3'd4,
      RESP  = 3'd5
   } state_e;

endpackage

// File: rtl/sonic_phy_mgmt_timer.sv
// rtl/sonic_phy_mgmt_timer.sv - waitrequest stall counter for the PHY management master
// Purpose: counts stall cycles of one bus transaction and flags the last allowed one.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  restart the count (held while no strobe is on the bus)
//   enable  in  count this cycle (strobe high and waitrequest high)
//   expired out high in the stall cycle that brings the count to LIMIT
module sonic_phy_mgmt_timer #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q, count_d;

   // Flag in the LIMIT-th stall cycle so the master drops the strobe on
   // that edge, leaving exactly LIMIT stalled strobe cycles on the bus.
   assign expired = enable && (count_q == CW'(LIMIT - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sonic_phy_mgmt_master.sv
// rtl/sonic_phy_mgmt_master.sv - Avalon-MM initiator for the SoNIC PMA phy_mgmt port
// Purpose: executes single read / write / read-modify-write / poll commands as
// bus transactions and returns one response per command.
// Optional feature: SONIC_MGMT_TIMEOUT_EN adds a waitrequest stall timeout.
// Ports:
//   phy_mgmt_clk, phy_mgmt_clk_reset         clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_op/address/data/mask   command handshake and fields
//   rsp_valid, rsp_data, rsp_error           one-cycle response
//   phy_mgmt_address/read/write/writedata    bus outputs (all registered)
//   phy_mgmt_readdata, phy_mgmt_waitrequest  bus inputs
module sonic_phy_mgmt_master
   import sonic_phy_mgmt_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int POLL_MAX       = 255,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              phy_mgmt_clk,
   input  logic              phy_mgmt_clk_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] phy_mgmt_address,
   output logic              phy_mgmt_read,
   output logic              phy_mgmt_write,
   output logic [DATA_W-1:0] phy_mgmt_writedata,
   input  logic [DATA_W-1:0] phy_mgmt_readdata,
   input  logic              phy_mgmt_waitrequest
);

   localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_error_q, rsp_error_d;
   logic [7:0]        attempts_q, attempts_d;

   logic              accept;
   logic              timeout_hit;
   logic              poll_match;
   logic [DATA_W-1:0] merged;

   assign cmd_ready  = (state_q == IDLE) && !phy_mgmt_clk_reset;
   assign accept     = cmd_valid && cmd_ready;
   assign poll_match = ((rd_q & mask_q) == (data_q & mask_q));
   assign merged     = (rd_q & ~mask_q) | (data_q & mask_q);

`ifdef SONIC_MGMT_TIMEOUT_EN
   // The count is held at zero whenever no strobe is on the bus, so it
   // restarts with every strobe assertion (including each poll re-read).
   sonic_phy_mgmt_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (phy_mgmt_clk),
      .rst     (phy_mgmt_clk_reset),
      .clear   (!(read_q || write_q)),
      .enable  ((read_q || write_q) && phy_mgmt_waitrequest),
      .expired (timeout_hit)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      data_d      = data_q;
      mask_d      = mask_q;
      rd_d        = rd_q;
      wdata_d     = wdata_q;
      read_d      = read_q;
      write_d     = write_q;
      attempts_d  = attempts_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d       = op_e'(cmd_op);
               addr_d     = cmd_address;
               data_d     = cmd_data;
               mask_d     = cmd_mask;
               attempts_d = 8'd0;
               if (op_e'(cmd_op) == OP_WRITE) begin
                  state_d = WR;
                  write_d = 1'b1;
                  wdata_d = cmd_data;
               end else begin
                  state_d = RD;
                  read_d  = 1'b1;
               end
            end
         end

         RD: begin
            if (timeout_hit) begin
               read_d      = 1'b0;
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
            end else if (!phy_mgmt_waitrequest) begin
               read_d     = 1'b0;
               rd_d       = phy_mgmt_readdata;
               attempts_d = attempts_q + 8'd1;
               case (op_q)
                  OP_RMW:  state_d = MERGE;
                  OP_POLL: state_d = CHECK;
                  default: begin
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = phy_mgmt_readdata;
                     rsp_error_d = 1'b0;
                  end
               endcase
            end
         end

         // Bus stays idle for one cycle while the merged value is registered.
         MERGE: begin
            state_d = WR;
            write_d = 1'b1;
            wdata_d = merged;
         end

         WR: begin
            if (timeout_hit) begin
               write_d     = 1'b0;
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
            end else if (!phy_mgmt_waitrequest) begin
               write_d     = 1'b0;
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = (op_q == OP_RMW) ? rd_q : '0;
               rsp_error_d = 1'b0;
            end
         end

         // Compare happens on the registered read value, which also
         // guarantees an idle bus cycle before any re-read.
         CHECK: begin
            if (poll_match) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rd_q;
               rsp_error_d = 1'b0;
            end else if (attempts_q < POLL_MAX_C) begin
               state_d = RD;
               read_d  = 1'b1;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rd_q;
               rsp_error_d = 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge phy_mgmt_clk) begin
      if (phy_mgmt_clk_reset) begin
         state_q     <= IDLE;
         op_q        <= OP_READ;
         addr_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
         rd_q        <= '0;
         wdata_q     <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         attempts_q  <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
         read_q      <= read_d;
         write_q     <= write_d;
         attempts_q  <= attempts_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign phy_mgmt_address   = addr_q;
   assign phy_mgmt_read      = read_q;
   assign phy_mgmt_write     = write_q;
   assign phy_mgmt_writedata = wdata_q;
   assign rsp_valid          = rsp_valid_q;
   assign rsp_data           = rsp_data_q;
   assign rsp_error          = rsp_error_q;

endmodule

// File: tb/tb_sonic_phy_mgmt_master.sv
// tb/tb_sonic_phy_mgmt_master.sv - self-checking bench for sonic_phy_mgmt_master
module tb_sonic_phy_mgmt_master;
   import sonic_phy_mgmt_pkg::*;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [8:0]  cmd_address;
   logic [31:0] cmd_data;
   logic [31:0] cmd_mask;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic [8:0]  phy_mgmt_address;
   logic        phy_mgmt_read;
   logic        phy_mgmt_write;
   logic [31:0] phy_mgmt_writedata;
   logic [31:0] phy_mgmt_readdata;
   logic        phy_mgmt_waitrequest;

   sonic_phy_mgmt_master #(
      .ADDR_W         (9),
      .DATA_W         (32),
      .POLL_MAX       (3),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .phy_mgmt_clk         (clk),
      .phy_mgmt_clk_reset   (rst),
      .cmd_valid            (cmd_valid),
      .cmd_ready            (cmd_ready),
      .cmd_op               (cmd_op),
      .cmd_address          (cmd_address),
      .cmd_data             (cmd_data),
      .cmd_mask             (cmd_mask),
      .rsp_valid            (rsp_valid),
      .rsp_data             (rsp_data),
      .rsp_error            (rsp_error),
      .phy_mgmt_address     (phy_mgmt_address),
      .phy_mgmt_read        (phy_mgmt_read),
      .phy_mgmt_write       (phy_mgmt_write),
      .phy_mgmt_writedata   (phy_mgmt_writedata),
      .phy_mgmt_readdata    (phy_mgmt_readdata),
      .phy_mgmt_waitrequest (phy_mgmt_waitrequest)
   );

   typedef struct {
      op_e         op;
      logic [8:0]  addr;
      logic [31:0] data;
      logic [31:0] mask;
      int          wait_n;
      logic [31:0] preload;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_mem;
      int          exp_hold;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rd_seq[$];
   logic [31:0] mem[0:511];
   vec_t        vecs[8];

   int tests;
   int fails;
   int cyc;
   int wait_n;
   int nrd;
   int nwr;
   int last_len;
   int stable_err;
   int both_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Slave model and response monitor, both evaluated away from the active edge.
   initial begin
      int          stall;
      int          cur_len;
      logic        prev_rd;
      logic        prev_wr;
      logic [8:0]  hold_addr;
      logic [31:0] hold_wd;
      exp_t        e;
      stall   = 0;
      cur_len = 0;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      hold_addr = '0;
      hold_wd   = '0;
      phy_mgmt_waitrequest = 1'b0;
      phy_mgmt_readdata    = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if (phy_mgmt_read && !prev_rd) nrd++;
         if (phy_mgmt_write && !prev_wr) nwr++;
         if (phy_mgmt_read && phy_mgmt_write) both_err++;
         if (phy_mgmt_read || phy_mgmt_write) begin
            if (!(prev_rd || prev_wr)) begin
               cur_len   = 0;
               hold_addr = phy_mgmt_address;
               hold_wd   = phy_mgmt_writedata;
            end else if (phy_mgmt_address != hold_addr || phy_mgmt_writedata != hold_wd) begin
               stable_err++;
            end
            cur_len++;
         end else if (prev_rd || prev_wr) begin
            last_len = cur_len;
         end
         prev_rd = phy_mgmt_read;
         prev_wr = phy_mgmt_write;

         if (rst || !(phy_mgmt_read || phy_mgmt_write)) begin
            stall = 0;
            phy_mgmt_waitrequest = 1'b0;
            phy_mgmt_readdata    = 32'hBAD0BAD0;
         end else if (stall < wait_n) begin
            stall++;
            phy_mgmt_waitrequest = 1'b1;
            phy_mgmt_readdata    = 32'hBAD0BAD0;
         end else begin
            stall = 0;
            phy_mgmt_waitrequest = 1'b0;
            if (phy_mgmt_read) begin
               if (rd_seq.size() != 0) phy_mgmt_readdata = rd_seq.pop_front();
               else phy_mgmt_readdata = mem[phy_mgmt_address];
            end
            if (phy_mgmt_write) mem[phy_mgmt_address] = phy_mgmt_writedata;
         end

         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
               check("rsp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic issue(input op_e op, input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] m, input logic exp_rsp, input logic [31:0] ed,
                        input logic ee, input int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_address = a;
      cmd_data    = d;
      cmd_mask    = m;
      #1;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!cmd_ready) begin
         check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      if (exp_rsp) sb.push_back('{ed, ee, cyc + lat});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      check("rsp_drain", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic clear_counts();
      nrd        = 0;
      nwr        = 0;
      last_len   = 0;
      stable_err = 0;
      both_err   = 0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      wait_n = 0;
      clear_counts();
      for (int i = 0; i < 512; i++) mem[i] = 32'd0;

      //          op        addr    data          mask          wt pre           exp_data      err lat rd wr mem           hold
      vecs[0] = '{OP_READ,  9'h044, 32'h0,        32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF, 1};
      vecs[1] = '{OP_WRITE, 9'h012, 32'h3,        32'h0,        5, 32'h0,        32'h0,        0, 7, 0, 1, 32'h00000003, 6};
      vecs[2] = '{OP_RMW,   9'h020, 32'h50,       32'hF0,       0, 32'h12345678, 32'h12345678, 0, 4, 1, 1, 32'h12345658, 1};
      vecs[3] = '{OP_RMW,   9'h021, 32'hABCD0000, 32'hFFFF0000, 2, 32'h11112222, 32'h11112222, 0, 8, 1, 1, 32'hABCD2222, 3};
      vecs[4] = '{OP_READ,  9'h1FF, 32'h0,        32'h0,        3, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 5, 1, 0, 32'h0F0F0F0F, 4};
      vecs[5] = '{OP_WRITE, 9'h000, 32'hFFFFFFFF, 32'h12345678, 0, 32'hA5A5A5A5, 32'h0,        0, 2, 0, 1, 32'hFFFFFFFF, 1};
      vecs[6] = '{OP_POLL,  9'h030, 32'h80,       32'h80,       0, 32'h000000C1, 32'h000000C1, 0, 3, 1, 0, 32'h000000C1, 1};
      vecs[7] = '{OP_POLL,  9'h031, 32'h05,       32'h0F,       1, 32'h000000F5, 32'h000000F5, 0, 4, 1, 0, 32'h000000F5, 2};

      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_address = '0;
      cmd_data    = '0;
      cmd_mask    = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("reset_strobes", {30'd0, phy_mgmt_read, phy_mgmt_write}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_address", {23'd0, phy_mgmt_address}, 32'd0);
      check("reset_writedata", phy_mgmt_writedata, 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         mem[vecs[i].addr] = vecs[i].preload;
         wait_n = vecs[i].wait_n;
         rd_seq.delete();
         clear_counts();
         issue(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b1,
               vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
         drain();
         check("vec_nrd", nrd, vecs[i].exp_nrd);
         check("vec_nwr", nwr, vecs[i].exp_nwr);
         check("vec_mem", mem[vecs[i].addr], vecs[i].exp_mem);
         check("vec_hold", last_len, vecs[i].exp_hold);
         check("vec_stable", stable_err, 32'd0);
         check("vec_exclusive", both_err, 32'd0);
      end

      // Poll that matches on the last allowed attempt (reads 1,1,0).
      wait_n = 0;
      mem[9'h00A] = 32'd1;
      clear_counts();
      rd_seq = '{32'd1, 32'd1, 32'd0};
      issue(OP_POLL, 9'h00A, 32'd0, 32'd1, 1'b1, 32'd0, 1'b0, 7);
      drain();
      check("poll_match_nrd", nrd, 32'd3);
      check("poll_match_nwr", nwr, 32'd0);

      // Poll that never matches: exhausted after POLL_MAX reads.
      clear_counts();
      rd_seq = '{32'd1, 32'd1, 32'd1};
      issue(OP_POLL, 9'h00A, 32'd0, 32'd1, 1'b1, 32'd1, 1'b1, 7);
      drain();
      check("poll_exhaust_nrd", nrd, 32'd3);
      rd_seq.delete();

      // Back-to-back reads: second accept no earlier than 3 cycles later.
      clear_counts();
      mem[9'h050] = 32'h0000AAAA;
      mem[9'h051] = 32'h0000BBBB;
      issue(OP_READ, 9'h050, 32'd0, 32'd0, 1'b1, 32'h0000AAAA, 1'b0, 2);
      issue(OP_READ, 9'h051, 32'd0, 32'd0, 1'b1, 32'h0000BBBB, 1'b0, 2);
      drain();
      check("b2b_nrd", nrd, 32'd2);

`ifdef SONIC_MGMT_TIMEOUT_EN
      // Stuck waitrequest: strobe dropped after 16 stall cycles, error response.
      clear_counts();
      wait_n = 100000;
      issue(OP_READ, 9'h070, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 17);
      drain();
      check("timeout_hold", last_len, 32'd16);
      check("timeout_nrd", nrd, 32'd1);
      wait_n = 0;
`endif

      // Reset in the middle of an RMW read that is stalling.
      clear_counts();
      wait_n = 3;
      mem[9'h040] = 32'h00000001;
      issue(OP_RMW, 9'h040, 32'hFF, 32'hFF, 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk);
      check("mid_rmw_read_active", {31'd0, phy_mgmt_read}, 32'd1);
      rst         = 1'b1;
      cmd_valid   = 1'b1;
      cmd_op      = OP_READ;
      cmd_address = 9'h055;
      #1;
      check("reset_cycle_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      cmd_valid = 1'b0;
      check("abort_strobes", {30'd0, phy_mgmt_read, phy_mgmt_write}, 32'd0);
      check("abort_address", {23'd0, phy_mgmt_address}, 32'd0);
      check("abort_writedata", phy_mgmt_writedata, 32'd0);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      #1;
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      check("reset_cmd_not_taken", {31'd0, phy_mgmt_read}, 32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_write", nwr, 32'd0);
      check("abort_mem", mem[9'h040], 32'h00000001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
